fetch_if: RTL and testbench
===========================

# fetch_if

Instruction-fetch stage that produces the IF/ID interface: owns the program counter, issues word reads to instruction memory over a request/grant/response handshake, and presents `isc` plus `pc_next_inw` to the decode-stage register. It honours the decode stall (`ena_n`) and branch redirect (`branch_taken`). When no instruction is ready it drives the all-zero NOP so the decode register always captures a legal word.

## Interface
- `ADR_BIT`, default `` `ADR_BIT ``: PC / memory address width.
- `ISC_BIT`, default `` `ISC_BIT ``: instruction width.
- `RESET_PC`, default 0: first fetch address after reset.
- `PC_STEP`, default 4: PC increment per instruction.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `branch_taken` in 1: redirect and flush request, same signal the decode register uses.
- `branch_target` in `ADR_BIT`: redirect address, sampled when `branch_taken`=1.
- `ena_n` in 1: decode stall; 1 means decode holds and does not consume `isc`.
- `imem_req` out 1: read request.
- `imem_addr` out `ADR_BIT`: request address, stable while `imem_req`=1 and not granted.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: read data valid, at least 1 cycle after grant, in order.
- `imem_rdata` in `ISC_BIT`: read data.
- `isc` out `ISC_BIT`: instruction to decode (registered).
- `pc_next_inw` out `ADR_BIT`: fetch address of `isc` + `PC_STEP` (registered).

## Operation
- Registers:
  - `pc`: next address to request.
  - `isc`/`pc_next_inw` output pair with an `out_full` flag.
  - One-entry buffer `buf_isc`/`buf_pc`/`buf_full`.
  - `discard` flag.
  - FSM.
- At most one read is outstanding. Capacity = output slot + buffer + outstanding. A request is never issued that could not land.
- FSM states:
  - REQ: `imem_req`=1, `imem_addr`=`pc`. On `imem_gnt`: `pc`+=`PC_STEP`, remember the address, go to WAIT.
  - WAIT: waiting for `imem_rvalid`. On `imem_rvalid`, go to REQ if space remains after the landing, else go to FULL. From WAIT, `imem_req` may assert in the same cycle `imem_rvalid`=1 (combinational from state) when space allows.
  - FULL: no request. Go to REQ on the first edge where a slot frees (`ena_n`=0).
- Consume rule: on an edge with `ena_n`=0, the current `isc` is consumed. The output then loads, in priority order:
  1. the buffer, if full;
  2. else the response arriving this cycle;
  3. else NOP (`isc`=0, `pc_next_inw`=0, `out_full`=0).
- On an edge with `ena_n`=1, the output holds. A response arriving this cycle goes to the output if `out_full`=0, else to the buffer.
- `branch_taken`=1 (highest priority after reset):
  - `isc`←0, `pc_next_inw`←0; `out_full` and `buf_full` cleared.
  - `pc`←`branch_target`.
  - If a read is outstanding (WAIT, or granted this cycle), set `discard`; the next `imem_rvalid` is dropped and clears `discard`. Otherwise go to REQ.
  - An ungranted REQ retargets to `branch_target` on the next cycle. This is the only case where `imem_addr` changes without a grant.
- PC arithmetic is modulo 2^`ADR_BIT`: `pc` wraps silently, as does `pc_next_inw`.

## Timing
- Reset (`rst_n`=0 at an edge):
  - `isc`=0, `pc_next_inw`=0, `imem_req`=0.
  - `pc`=`RESET_PC`; buffer and `discard` cleared; state REQ.
  - First `imem_req`=1 appears in the cycle after reset is released.
- Reset mid-transaction drops any outstanding response: `discard` is set if the state was WAIT.
- Latency with 0-wait grant and 1-cycle `rvalid`: request cycle N → `isc` valid from N+2.
- Steady-state throughput is one instruction per cycle.
- `branch_taken` at edge E:
  - NOP on `isc` from E.
  - Target instruction on `isc` no earlier than E+2 (E+3 if a discard was pending).
- Simultaneous `branch_taken` and `ena_n`=1: branch wins; outputs flush.
- `imem_rvalid` while in REQ or FULL is a protocol error and is ignored.

## Structure
- Shared package/header (`global_macro.v`): `ADR_BIT`, `ISC_BIT`, a `NOP_ISC` constant (all zeros), and the FSM state encodings (REQ, WAIT, FULL).
- Natural sub-module: `fetch_skid`, the one-entry buffer with load/pop/flush. The remainder stays flat.

## Test plan
- Reset release, `RESET_PC`=0, memory returns 0x11111111, 0x22222222 with 1-cycle latency, `ena_n`=0 → addresses 0, 4, 8…; `isc`=0x11111111 with `pc_next_inw`=4, then 0x22222222 with 8, on consecutive cycles.
- Hold `ena_n`=1 for 5 cycles mid-stream → `isc` stable. Exactly one further word is buffered and `imem_req` drops. On release, the buffered word appears next with no loss or duplication.
- `branch_taken` with `branch_target`=0x100 while a read of 0x10 is outstanding → `isc`=0 next cycle, the 0x10 response is dropped, next request address is 0x100, and the 0x100 word carries `pc_next_inw`=0x104.
- `imem_gnt` withheld 3 cycles → `imem_req` and `imem_addr` stay stable; `isc` stays NOP with `ena_n`=0.
- `pc`=0xFFFFFFFC (`ADR_BIT`=32) → next request address is 0x0; `pc_next_inw`=0x0 for that word.
- `rst_n`=0 while in WAIT → outputs return to reset values. The late response is discarded; the first post-reset `isc` comes from `RESET_PC`.

Source files
------------

// File: rtl/fetch_if_pkg.sv
// Shared widths, NOP encoding and fetch FSM states for the instruction-fetch stage.
package fetch_if_pkg;

    localparam int unsigned ADR_BIT = 32;
    localparam int unsigned ISC_BIT = 32;

    localparam logic [ISC_BIT-1:0] NOP_ISC = '0;

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_FULL
    } fetch_state_t;

endpackage

// File: rtl/fetch_if_skid.sv
// One-entry instruction buffer: holds a landed word while decode stalls with the output slot full.
module fetch_if_skid #(
    parameter int unsigned ADR_BIT = fetch_if_pkg::ADR_BIT,
    parameter int unsigned ISC_BIT = fetch_if_pkg::ISC_BIT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               load,
    input  logic               pop,
    input  logic [ISC_BIT-1:0] load_isc,
    input  logic [ADR_BIT-1:0] load_pc,
    output logic               full,
    output logic [ISC_BIT-1:0] buf_isc,
    output logic [ADR_BIT-1:0] buf_pc
);

    // A pop and load on the same edge leaves the buffer full with the new word.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            full    <= 1'b0;
            buf_isc <= '0;
            buf_pc  <= '0;
        end else if (load) begin
            full    <= 1'b1;
            buf_isc <= load_isc;
            buf_pc  <= load_pc;
        end else if (pop) begin
            full    <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_if.sv
// Instruction-fetch stage: owns the PC, reads instruction memory over req/gnt/rvalid and
// feeds isc / pc_next_inw to the decode register, with stall, redirect and NOP fill.
module fetch_if #(
    parameter int unsigned         ADR_BIT  = fetch_if_pkg::ADR_BIT,
    parameter int unsigned         ISC_BIT  = fetch_if_pkg::ISC_BIT,
    parameter logic [ADR_BIT-1:0]  RESET_PC = '0,
    parameter logic [ADR_BIT-1:0]  PC_STEP  = ADR_BIT'(4)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               branch_taken,
    input  logic [ADR_BIT-1:0] branch_target,
    input  logic               ena_n,
    output logic               imem_req,
    output logic [ADR_BIT-1:0] imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [ISC_BIT-1:0] imem_rdata,
    output logic [ISC_BIT-1:0] isc,
    output logic [ADR_BIT-1:0] pc_next_inw
);
    import fetch_if_pkg::*;

    fetch_state_t       state;
    logic               run;
    logic               discard;
    logic               out_full;
    logic [ADR_BIT-1:0] pc;
    logic [ADR_BIT-1:0] wait_pc_next;

    logic               buf_full;
    logic [ISC_BIT-1:0] buf_isc;
    logic [ADR_BIT-1:0] buf_pc;

    logic consume, landing, granted, buf_full_nx, still_out, buf_load, buf_pop;

    // A request is only raised when the word it returns is guaranteed a slot; since the
    // buffer only fills behind a full output slot, "buffer empty after this edge" is that test.
    always_comb begin
        consume     = !ena_n;
        landing     = imem_rvalid && !discard && (state == ST_WAIT);
        buf_full_nx = consume ? (buf_full && landing) : (buf_full || (landing && out_full));
        imem_req    = run && !discard &&
                      ((state == ST_REQ) || ((state == ST_WAIT) && imem_rvalid && !buf_full_nx));
        granted     = imem_req && imem_gnt;
        still_out   = granted || (((state == ST_WAIT) || discard) && !imem_rvalid);
        buf_load    = landing && (consume ? buf_full : out_full);
        buf_pop     = consume && buf_full;
    end

    assign imem_addr = pc;

    fetch_if_skid #(
        .ADR_BIT (ADR_BIT),
        .ISC_BIT (ISC_BIT)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (branch_taken),
        .load     (buf_load),
        .pop      (buf_pop),
        .load_isc (imem_rdata),
        .load_pc  (wait_pc_next),
        .full     (buf_full),
        .buf_isc  (buf_isc),
        .buf_pc   (buf_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_REQ;
            run          <= 1'b0;
            pc           <= RESET_PC;
            wait_pc_next <= '0;
            discard      <= still_out;
            isc          <= ISC_BIT'(NOP_ISC);
            pc_next_inw  <= '0;
            out_full     <= 1'b0;
        end else if (branch_taken) begin
            run         <= 1'b1;
            pc          <= branch_target;
            discard     <= still_out;
            state       <= (granted || ((state == ST_WAIT) && !imem_rvalid)) ? ST_WAIT : ST_REQ;
            isc         <= ISC_BIT'(NOP_ISC);
            pc_next_inw <= '0;
            out_full    <= 1'b0;
        end else begin
            run <= 1'b1;
            if (granted) begin
                pc           <= pc + PC_STEP;
                wait_pc_next <= pc + PC_STEP;
            end
            if (discard && imem_rvalid) discard <= 1'b0;

            case (state)
                ST_REQ:  if (granted) state <= ST_WAIT;
                ST_WAIT: if (imem_rvalid && !granted)
                             state <= (discard || !buf_full_nx) ? ST_REQ : ST_FULL;
                ST_FULL: if (consume) state <= ST_REQ;
                default: state <= ST_REQ;
            endcase

            if (consume) begin
                if (buf_full) begin
                    isc         <= buf_isc;
                    pc_next_inw <= buf_pc;
                    out_full    <= 1'b1;
                end else if (landing) begin
                    isc         <= imem_rdata;
                    pc_next_inw <= wait_pc_next;
                    out_full    <= 1'b1;
                end else begin
                    isc         <= ISC_BIT'(NOP_ISC);
                    pc_next_inw <= '0;
                    out_full    <= 1'b0;
                end
            end else if (landing && !out_full) begin
                isc         <= imem_rdata;
                pc_next_inw <= wait_pc_next;
                out_full    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_if.sv
// Randomized bench for fetch_if: an in-order memory model plus an instruction-stream
// reference (expected fetch/delivery addresses) checks every consumed word.
module tb_fetch_if;

    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        ena_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] isc;
    logic [31:0] pc_next_inw;

    always #5 clk = ~clk;

    fetch_if #(
        .ADR_BIT  (32),
        .ISC_BIT  (32),
        .RESET_PC (RST_PC),
        .PC_STEP  (32'h4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ena_n         (ena_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .isc           (isc),
        .pc_next_inw   (pc_next_inw)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rd_t;

    rd_t         mq[$];
    int          cyc = 0;
    int          first_req = -1;
    int unsigned n_chk = 0, n_pass = 0, delivered = 0;
    int unsigned gnt_pct = 100, lat_lo = 1, lat_hi = 1;
    logic [31:0] exp_addr = RST_PC, req_exp = RST_PC, prev_addr = '0, prev_isc = '0;
    logic        post_rst = 1'b0, post_br = 1'b0, hold_prev = 1'b0, stall_prev = 1'b0;
    logic        seen_wrap = 1'b0, lat_armed = 1'b0;

    // Memory contents: never zero, so a zero isc always means NOP.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return ((a * 32'h9E37_79B1) ^ 32'hA5A5_0000) | 32'h1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic step(input logic r, input logic b, input logic [31:0] t, input logic e);
        logic        req_s, gnt_s, rv_s;
        logic [31:0] addr_s, isc_s, pcn_s;
        rd_t         rd;
        @(negedge clk);
        rst_n = r; branch_taken = b; branch_target = t; ena_n = e;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1; imem_rdata = mem(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0; imem_rdata = $urandom();
        end
        #1;
        imem_gnt = (imem_req === 1'b1) && ($urandom_range(99) < gnt_pct);
        #1;
        req_s = imem_req; gnt_s = imem_gnt; rv_s = imem_rvalid;
        addr_s = imem_addr; isc_s = isc; pcn_s = pc_next_inw;

        if (post_rst) begin
            chk("rst_isc", isc_s, 32'h0);
            chk("rst_pcn", pcn_s, 32'h0);
            chk("rst_req", 32'(req_s), 32'h0);
        end
        if (post_br) begin
            chk("br_isc", isc_s, 32'h0);
            chk("br_pcn", pcn_s, 32'h0);
        end
        if (hold_prev) begin
            chk("req_hold", 32'(req_s), 32'h1);
            chk("addr_hold", addr_s, prev_addr);
        end
        if (stall_prev && prev_isc != 0) chk("stall_hold", isc_s, prev_isc);
        if (isc_s == 0) chk("nop_pcn", pcn_s, 32'h0);
        if (lat_armed) begin
            if (first_req < 0 && req_s === 1'b1) first_req = cyc;
            if (first_req >= 0 && cyc == first_req + 1) chk("lat_n1_nop", isc_s, 32'h0);
            if (first_req >= 0 && cyc == first_req + 2) begin
                chk("lat_n2_isc", isc_s, mem(RST_PC));
                chk("lat_n2_pcn", pcn_s, RST_PC + 32'h4);
            end
            if (first_req >= 0 && cyc == first_req + 3) begin
                chk("lat_n3_isc", isc_s, mem(RST_PC + 32'h4));
                chk("lat_n3_pcn", pcn_s, RST_PC + 32'h8);
                lat_armed = 1'b0;
            end
        end

        @(posedge clk);
        if (rv_s) void'(mq.pop_front());
        if (req_s === 1'b1 && gnt_s) begin
            chk("req_addr", addr_s, req_exp);
            chk("one_outst", 32'(mq.size()), 32'h0);
            rd.addr = addr_s;
            rd.due  = cyc + int'($urandom_range(lat_hi, lat_lo));
            mq.push_back(rd);
            req_exp = req_exp + 32'h4;
        end
        if (!r) begin
            exp_addr = RST_PC; req_exp = RST_PC;
        end else if (b) begin
            exp_addr = t; req_exp = t;
        end else if (!e && isc_s != 0) begin
            chk("isc", isc_s, mem(exp_addr));
            chk("pcn", pcn_s, exp_addr + 32'h4);
            if (exp_addr == 32'hFFFF_FFFC) seen_wrap = 1'b1;
            exp_addr = exp_addr + 32'h4;
            delivered++;
        end
        post_rst   = !r;
        post_br    = r && b;
        hold_prev  = r && !b && (req_s === 1'b1) && !gnt_s;
        prev_addr  = addr_s;
        stall_prev = r && !b && e;
        prev_isc   = isc_s;
        cyc++;
    endtask

    task automatic wait_outst(input int unsigned lim);
        int unsigned n = 0;
        while (mq.size() == 0 && n < lim) begin
            step(1'b1, 1'b0, 32'h0, 1'b0);
            n++;
        end
        chk("wait_outst", 32'(mq.size() != 0), 32'h1);
    endtask

    task automatic wait_req(input int unsigned lim);
        int unsigned n = 0;
        #2;
        while (imem_req !== 1'b1 && n < lim) begin
            step(1'b1, 1'b0, 32'h0, 1'b0);
            #2;
            n++;
        end
        chk("wait_req", 32'(imem_req), 32'h1);
    endtask

    initial begin
        logic [31:0] tgt;
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Straight-line fetch, zero-wait grant, 1-cycle data
        lat_armed = 1'b1;
        repeat (10) step(1'b1, 1'b0, 32'h0, 1'b0);

        // Decode stall: one word buffered, request stops
        repeat (5) step(1'b1, 1'b0, 32'h0, 1'b1);
        #2;
        chk("stall_req_drop", 32'(imem_req), 32'h0);
        chk("stall_outst", 32'(mq.size()), 32'h0);
        repeat (6) step(1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect with a read outstanding, then withheld grants
        lat_lo = 3; lat_hi = 3;
        wait_outst(20);
        step(1'b1, 1'b1, 32'h100, 1'b0);
        wait_req(10);
        gnt_pct = 0;
        repeat (3) begin
            step(1'b1, 1'b0, 32'h0, 1'b0);
            #2;
            chk("gnt_wait_nop", isc, 32'h0);
        end
        gnt_pct = 100; lat_lo = 1; lat_hi = 1;
        repeat (10) step(1'b1, 1'b0, 32'h0, 1'b0);

        // PC wrap across the top of the address space
        step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
        repeat (12) step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("wrap_seen", 32'(seen_wrap), 32'h1);

        // Reset while a read is outstanding
        lat_lo = 3; lat_hi = 3;
        wait_outst(20);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (15) step(1'b1, 1'b0, 32'h0, 1'b0);

        // Random traffic
        gnt_pct = 70; lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 4000; i++) begin
            tgt = ($urandom_range(7) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
            step(($urandom_range(299) != 0), ($urandom_range(49) == 0), tgt,
                 ($urandom_range(99) < 30));
        end
        chk("progress", 32'(delivered > 300), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
